uart_tx_arbiter: RTL and testbench

Shares one UART transmitter between `NUM_REQ` byte-stream requesters using round-robin arbitration with packet locking. Once a requester wins, it keeps the transmitter until it sends a byte flagged `last`. The block sits between the client logic and the UART's `transmit`/`tx_byte`/`is_transmitting` ports. It sequences the UART's level-sensitive `transmit` handshake, which must drop low before the UART returns to idle, so clients only see a valid/ready interface.

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: sequencing states and the
// width helper used to size grant_idx / rr_ptr.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        LAUNCH,
        DRAIN
    } arb_state_t;

    // One bit is still needed when there are only two requesters.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester searching upward,
// with wrap, from rr_ptr+1.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [idx_width(NUM_REQ)-1:0] rr_ptr,
    output logic [idx_width(NUM_REQ)-1:0] winner,
    output logic                          any_valid
);
    localparam int GW = idx_width(NUM_REQ);

    logic [GW-1:0]      cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_valid;

    // Candidate gi is the requester gi+1 places after rr_ptr, modulo NUM_REQ,
    // so non-power-of-2 counts wrap correctly.
    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [GW:0] sum;
        assign sum            = {1'b0, rr_ptr} + (GW+1)'(gi + 1);
        assign cand_idx[gi]   = (sum >= (GW+1)'(NUM_REQ)) ? GW'(sum - (GW+1)'(NUM_REQ))
                                                          : GW'(sum);
        assign cand_valid[gi] = req_valid[cand_idx[gi]];
    end

    assign any_valid = |req_valid;

    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_valid[k]) winner = cand_idx[k];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter among NUM_REQ
// byte streams. Define UART_ARB_TIMEOUT_EN to enable the lock watchdog.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [8*NUM_REQ-1:0]          req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          uart_transmit,
    output logic [7:0]                    uart_tx_byte,
    input  logic                          uart_is_transmitting,
    output logic                          grant_valid,
    output logic [idx_width(NUM_REQ)-1:0] grant_idx,
    output logic                          timeout_err
);
    localparam int GW = idx_width(NUM_REQ);

    arb_state_t    state_reg;
    logic [GW-1:0] rr_ptr_reg;
    logic          hold_last_reg;
    logic [GW-1:0] rr_winner;
    logic          rr_any;
    logic          handshake;
    logic [7:0]    sel_data;
    logic          sel_last;
    logic          wd_hit;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_reg),
        .winner    (rr_winner),
        .any_valid (rr_any)
    );

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = (state_reg == ACCEPT) && (grant_idx == GW'(gi))
                               && !uart_is_transmitting;
    end

    assign handshake = |(req_valid & req_ready);
    assign sel_data  = req_data[{grant_idx, 3'b000} +: 8];
    assign sel_last  = req_last[grant_idx];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt_reg;
    logic          wd_run;

    // wd_run drops on every exit from ACCEPT/LAUNCH, which is what clears the count.
    assign wd_run = ((state_reg == ACCEPT) && grant_valid && !handshake)
                 || ((state_reg == LAUNCH) && !uart_is_transmitting);
    assign wd_hit = wd_run && (wd_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !wd_run || wd_hit) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_reg + CW'(1);
        end
    end
`else
    // Watchdog compiled out: a positive cycle limit makes this constant 0.
    assign wd_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= GW'(NUM_REQ - 1);
            hold_last_reg <= 1'b0;
            grant_valid   <= 1'b0;
            grant_idx     <= '0;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= '0;
            timeout_err   <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rr_any) begin
                        grant_idx   <= rr_winner;
                        grant_valid <= 1'b1;
                        state_reg   <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (handshake) begin
                        uart_tx_byte  <= sel_data;
                        hold_last_reg <= sel_last;
                        uart_transmit <= 1'b1;
                        state_reg     <= LAUNCH;
                    end else if (wd_hit) begin
                        timeout_err <= 1'b1;
                        grant_valid <= 1'b0;
                        rr_ptr_reg  <= grant_idx;
                        state_reg   <= IDLE;
                    end
                end
                LAUNCH: begin
                    // The UART's transmit is level-sensitive: drop it once busy is seen.
                    if (uart_is_transmitting) begin
                        uart_transmit <= 1'b0;
                        state_reg     <= DRAIN;
                    end else if (wd_hit) begin
                        timeout_err   <= 1'b1;
                        uart_transmit <= 1'b0;
                        grant_valid   <= 1'b0;
                        rr_ptr_reg    <= grant_idx;
                        state_reg     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!uart_is_transmitting) begin
                        if (hold_last_reg) begin
                            grant_valid <= 1'b0;
                            rr_ptr_reg  <= grant_idx;
                            state_reg   <= IDLE;
                        end else begin
                            state_reg <= ACCEPT;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART that logs each
// launched byte together with the granted requester.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int GW    = 2;
    localparam int FRAME = 10;
    localparam int TO    = 16;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int STALL_CYCLES = 10;
`else
    localparam int STALL_CYCLES = 50;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [8*N-1:0]  req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            uart_transmit;
    logic [7:0]      uart_tx_byte;
    logic            uart_is_transmitting;
    logic            grant_valid;
    logic [GW-1:0]   grant_idx;
    logic            timeout_err;

    logic [8:0]      pq [N][$];
    logic [15:0]     tx_log [$];
    logic            uart_mute = 1'b0;
    int              frame_cnt;
    int              proto_err = 0;
    int              tests_run = 0;
    int              tests_failed = 0;
    int              inv_err = 0;
    int              to_pulses = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ              (N),
        .TIMEOUT_CYCLES       (TO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_data             (req_data),
        .req_last             (req_last),
        .req_ready            (req_ready),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .grant_valid          (grant_valid),
        .grant_idx            (grant_idx),
        .timeout_err          (timeout_err)
    );

    // Behavioural UART: goes busy the edge after transmit is seen, for FRAME cycles.
    always @(posedge clk) begin
        if (rst) begin
            uart_is_transmitting <= 1'b0;
            frame_cnt            <= 0;
        end else if (!uart_is_transmitting) begin
            if (uart_transmit && !uart_mute) begin
                uart_is_transmitting <= 1'b1;
                frame_cnt            <= FRAME;
                tx_log.push_back({8'(grant_idx), uart_tx_byte});
                $display("[TB] uart byte req=%0d data=%02h at %0t", grant_idx, uart_tx_byte, $time);
            end
        end else begin
            if (frame_cnt == 1) begin
                uart_is_transmitting <= 1'b0;
                if (uart_transmit) proto_err <= proto_err + 1;
            end
            frame_cnt <= frame_cnt - 1;
        end
    end

    task automatic apply_drive();
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0) begin
                h = pq[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = h[7:0];
                req_last[i]        = h[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic drive_cycle();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        if (req_ready != '0) begin
            if (!grant_valid || uart_is_transmitting || req_ready != (N'(1) << grant_idx))
                inv_err++;
        end
        if (timeout_err) to_pulses++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) void'(pq[i].pop_front());
        end
        apply_drive();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run_until_drained(input int max_cycles, input string name);
        int n = 0;
        do begin
            drive_cycle();
            n++;
        end while (!(all_empty() && !grant_valid && !uart_is_transmitting && !uart_transmit)
                   && n < max_cycles);
        tests_run++;
        if (!(all_empty() && !grant_valid && !uart_is_transmitting && !uart_transmit)) begin
            tests_failed++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) pq[i].delete();
        apply_drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tests_run += 7;
        if (req_ready !== '0)       begin tests_failed++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        if (uart_transmit !== 1'b0) begin tests_failed++; $display("FAIL reset_transmit: got %b want 0", uart_transmit); end
        if (uart_tx_byte !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_byte: got %02h want 00", uart_tx_byte); end
        if (grant_valid !== 1'b0)   begin tests_failed++; $display("FAIL reset_grant_valid: got %b want 0", grant_valid); end
        if (grant_idx !== 2'd0)     begin tests_failed++; $display("FAIL reset_grant_idx: got %0d want 0", grant_idx); end
        if (timeout_err !== 1'b0)   begin tests_failed++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        if (dut.rr_ptr_reg !== 2'd3) begin tests_failed++; $display("FAIL reset_rr_ptr: got %0d want 3", dut.rr_ptr_reg); end
    endtask

    task automatic test_single_byte();
        tx_log.delete();
        req_valid[0]    = 1'b1;
        req_data[7:0]   = 8'h55;
        req_last[0]     = 1'b1;
        @(posedge clk); #1;
        tests_run += 3;
        if (grant_valid !== 1'b1)  begin tests_failed++; $display("FAIL single_grant_valid: got %b want 1", grant_valid); end
        if (grant_idx !== 2'd0)    begin tests_failed++; $display("FAIL single_grant_idx: got %0d want 0", grant_idx); end
        if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        tests_run += 3;
        if (uart_transmit !== 1'b1) begin tests_failed++; $display("FAIL single_launch: got %b want 1", uart_transmit); end
        if (uart_tx_byte !== 8'h55) begin tests_failed++; $display("FAIL single_tx_byte: got %02h want 55", uart_tx_byte); end
        if (req_ready !== 4'b0000)  begin tests_failed++; $display("FAIL single_ready_drop: got %b want 0000", req_ready); end
        @(posedge clk); #1;
        tests_run++;
        if (uart_transmit !== 1'b1) begin tests_failed++; $display("FAIL single_hold_until_busy: got %b want 1", uart_transmit); end
        @(posedge clk); #1;
        tests_run++;
        if (uart_transmit !== 1'b0) begin tests_failed++; $display("FAIL single_drop_after_busy: got %b want 0", uart_transmit); end
        for (int n = 0; n < 100 && grant_valid; n++) begin
            @(posedge clk); #1;
        end
        tests_run += 4;
        if (grant_valid !== 1'b0)    begin tests_failed++; $display("FAIL single_release: got %b want 0", grant_valid); end
        if (dut.rr_ptr_reg !== 2'd0) begin tests_failed++; $display("FAIL single_rr_ptr: got %0d want 0", dut.rr_ptr_reg); end
        if (tx_log.size() != 1)      begin tests_failed++; $display("FAIL single_count: got %0d want 1", tx_log.size()); end
        if (tx_log.size() < 1 || tx_log[0] !== 16'h0055) begin
            tests_failed++; $display("FAIL single_line: got %04h want 0055", (tx_log.size() > 0) ? tx_log[0] : 16'hffff);
        end
    endtask

    task automatic test_packet_lock();
        logic [15:0] exp [4];
        exp = '{16'h0101, 16'h0102, 16'h0103, 16'h02A0};
        tx_log.delete();
        inv_err = 0;
        pq[1].push_back({1'b0, 8'h01});
        pq[1].push_back({1'b0, 8'h02});
        pq[1].push_back({1'b1, 8'h03});
        pq[2].push_back({1'b1, 8'hA0});
        apply_drive();
        run_until_drained(400, "lock");
        tests_run += 2;
        if (tx_log.size() != 4) begin tests_failed++; $display("FAIL lock_count: got %0d want 4", tx_log.size()); end
        if (inv_err != 0)       begin tests_failed++; $display("FAIL lock_ready_onehot: got %0d bad cycles want 0", inv_err); end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (k >= tx_log.size() || tx_log[k] !== exp[k]) begin
                tests_failed++;
                $display("FAIL lock_order[%0d]: got %04h want %04h", k, (k < tx_log.size()) ? tx_log[k] : 16'hffff, exp[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp [8];
        int repeats = 0;
        exp = '{16'h0010, 16'h0111, 16'h0212, 16'h0313, 16'h0020, 16'h0121, 16'h0222, 16'h0323};
        do_reset();
        tx_log.delete();
        inv_err = 0;
        for (int i = 0; i < N; i++) begin
            pq[i].push_back({1'b1, 8'h10 + 8'(i)});
            pq[i].push_back({1'b1, 8'h20 + 8'(i)});
        end
        apply_drive();
        run_until_drained(800, "rr");
        for (int k = 1; k < tx_log.size(); k++) begin
            if (tx_log[k][15:8] == tx_log[k-1][15:8]) repeats++;
        end
        tests_run += 3;
        if (tx_log.size() != 8) begin tests_failed++; $display("FAIL rr_count: got %0d want 8", tx_log.size()); end
        if (repeats != 0)       begin tests_failed++; $display("FAIL rr_repeat: got %0d repeats want 0", repeats); end
        if (inv_err != 0)       begin tests_failed++; $display("FAIL rr_ready_onehot: got %0d bad cycles want 0", inv_err); end
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (k >= tx_log.size() || tx_log[k] !== exp[k]) begin
                tests_failed++;
                $display("FAIL rr_order[%0d]: got %04h want %04h", k, (k < tx_log.size()) ? tx_log[k] : 16'hffff, exp[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp [3];
        int lapses = 0;
        int n = 0;
        exp = '{16'h0331, 16'h0332, 16'h0141};
        tx_log.delete();
        inv_err = 0;
        pq[3].push_back({1'b0, 8'h31});
        apply_drive();
        while (pq[3].size() != 0 && n < 100) begin
            drive_cycle();
            n++;
        end
        pq[1].push_back({1'b1, 8'h41});
        apply_drive();
        for (int c = 0; c < STALL_CYCLES; c++) begin
            drive_cycle();
            if (!grant_valid || grant_idx != 2'd3) lapses++;
        end
        tests_run += 2;
        if (lapses != 0)        begin tests_failed++; $display("FAIL stall_lock_held: got %0d lapses want 0", lapses); end
        if (tx_log.size() != 1) begin tests_failed++; $display("FAIL stall_no_other: got %0d bytes want 1", tx_log.size()); end
        pq[3].push_back({1'b1, 8'h32});
        apply_drive();
        run_until_drained(400, "stall");
        tests_run++;
        if (inv_err != 0) begin tests_failed++; $display("FAIL stall_ready_onehot: got %0d bad cycles want 0", inv_err); end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (k >= tx_log.size() || tx_log[k] !== exp[k]) begin
                tests_failed++;
                $display("FAIL stall_order[%0d]: got %04h want %04h", k, (k < tx_log.size()) ? tx_log[k] : 16'hffff, exp[k]);
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        tx_log.delete();
        to_pulses = 0;
        pq[0].push_back({1'b0, 8'h77});
        apply_drive();
        while (pq[0].size() != 0 && n < 100) begin
            drive_cycle();
            n++;
        end
        pq[1].push_back({1'b1, 8'h88});
        apply_drive();
`ifdef UART_ARB_TIMEOUT_EN
        run_until_drained(300, "timeout");
        tests_run += 3;
        if (to_pulses != 1) begin tests_failed++; $display("FAIL timeout_pulse: got %0d cycles high want 1", to_pulses); end
        if (tx_log.size() != 2) begin tests_failed++; $display("FAIL timeout_count: got %0d want 2", tx_log.size()); end
        if (tx_log.size() < 2 || tx_log[1] !== 16'h0188) begin
            tests_failed++; $display("FAIL timeout_next_grant: got %04h want 0188", (tx_log.size() > 1) ? tx_log[1] : 16'hffff);
        end
`else
        for (int c = 0; c < 60; c++) drive_cycle();
        tests_run += 3;
        if (to_pulses != 0) begin tests_failed++; $display("FAIL timeout_off_pulse: got %0d want 0", to_pulses); end
        if (!grant_valid || grant_idx !== 2'd0) begin
            tests_failed++; $display("FAIL timeout_off_lock: got valid=%b idx=%0d want valid=1 idx=0", grant_valid, grant_idx);
        end
        if (tx_log.size() != 1) begin tests_failed++; $display("FAIL timeout_off_count: got %0d want 1", tx_log.size()); end
`endif
    endtask

    task automatic test_reset_mid_launch();
        int n = 0;
        do_reset();
        tx_log.delete();
        uart_mute = 1'b1;
        pq[0].push_back({1'b1, 8'h5A});
        apply_drive();
        while (!uart_transmit && n < 20) begin
            drive_cycle();
            n++;
        end
        repeat (5) drive_cycle();
        tests_run += 2;
        if (uart_transmit !== 1'b1) begin tests_failed++; $display("FAIL launch_wait_ack: got %b want 1", uart_transmit); end
        if (uart_tx_byte !== 8'h5A) begin tests_failed++; $display("FAIL launch_byte: got %02h want 5a", uart_tx_byte); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run += 6;
        if (uart_transmit !== 1'b0) begin tests_failed++; $display("FAIL midrst_transmit: got %b want 0", uart_transmit); end
        if (uart_tx_byte !== 8'h00) begin tests_failed++; $display("FAIL midrst_tx_byte: got %02h want 00", uart_tx_byte); end
        if (grant_valid !== 1'b0)   begin tests_failed++; $display("FAIL midrst_grant_valid: got %b want 0", grant_valid); end
        if (grant_idx !== 2'd0)     begin tests_failed++; $display("FAIL midrst_grant_idx: got %0d want 0", grant_idx); end
        if (req_ready !== '0)       begin tests_failed++; $display("FAIL midrst_ready: got %b want 0000", req_ready); end
        if (dut.rr_ptr_reg !== 2'd3) begin tests_failed++; $display("FAIL midrst_rr_ptr: got %0d want 3", dut.rr_ptr_reg); end
        rst = 1'b0;
        uart_mute = 1'b0;
        for (int i = 0; i < N; i++) pq[i].delete();
        pq[2].push_back({1'b1, 8'h62});
        pq[0].push_back({1'b1, 8'h61});
        apply_drive();
        run_until_drained(300, "midrst");
        tests_run += 3;
        if (tx_log.size() != 2) begin tests_failed++; $display("FAIL midrst_count: got %0d want 2", tx_log.size()); end
        if (tx_log.size() < 1 || tx_log[0] !== 16'h0061) begin
            tests_failed++; $display("FAIL midrst_first: got %04h want 0061", (tx_log.size() > 0) ? tx_log[0] : 16'hffff);
        end
        if (tx_log.size() < 2 || tx_log[1] !== 16'h0262) begin
            tests_failed++; $display("FAIL midrst_second: got %04h want 0262", (tx_log.size() > 1) ? tx_log[1] : 16'hffff);
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single_byte();
        test_packet_lock();
        test_round_robin();
        test_stall();
        test_timeout();
        test_reset_mid_launch();
        tests_run++;
        if (proto_err != 0) begin
            tests_failed++; $display("FAIL uart_protocol: transmit high at frame end %0d times, want 0", proto_err);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
